// File: rtl/muldiv_sequencer.sv
// Iterative RV32 M-extension multiply/divide engine: one bit per cycle, stall held while busy.
// Optional signed semantics when MULDIV_SIGNED_EN is defined; otherwise all ops are unsigned.
module muldiv_sequencer #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic            sgn,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [4:0]      rd_in,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out,
    output logic            regwrite
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_MULH = 2'b01;
    localparam logic [1:0] OP_DIV  = 2'b10;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  count;
    logic [XLEN:0]     hi;      // product high word / partial remainder
    logic [XLEN-1:0]   lo;      // product low word / quotient
    logic [XLEN-1:0]   opd;     // multiplicand or divisor
    logic [1:0]        op_q;
    logic [4:0]        rd_q;

    logic              is_div, div_zero, last_iter;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [XLEN:0]     mul_sum, div_shift, div_sub;
    logic              div_ge;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, remv, res_sel;

    assign is_div    = op[1];
    assign div_zero  = is_div && (b == '0);
    assign last_iter = (count == CNT_W'(XLEN - 1));

`ifdef MULDIV_SIGNED_EN
    logic a_neg, b_neg, neg_q, rneg_q, dz_q;
    assign a_neg = sgn & a[XLEN-1];
    assign b_neg = sgn & b[XLEN-1];
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;
`else
    logic unused_sgn;
    assign unused_sgn = sgn;
    assign a_mag      = a;
    assign b_mag      = b;
`endif

    // Shift-add multiply step: add multiplicand on lo[0], then shift {hi,lo} right.
    assign mul_sum   = hi + (lo[0] ? {1'b0, opd} : '0);
    // Restoring divide step: shift next dividend bit in, subtract if it fits.
    assign div_shift = {hi[XLEN-1:0], lo[XLEN-1]};
    assign div_ge    = (div_shift >= {1'b0, opd});
    assign div_sub   = div_shift - {1'b0, opd};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = div_zero ? DONE : RUN;
            RUN:     if (last_iter) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            hi     <= '0;
            lo     <= '0;
            opd    <= '0;
            op_q   <= '0;
            rd_q   <= '0;
`ifdef MULDIV_SIGNED_EN
            neg_q  <= 1'b0;
            rneg_q <= 1'b0;
            dz_q   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (start) begin
                    op_q  <= op;
                    rd_q  <= rd_in;
                    count <= '0;
                    opd   <= is_div ? b_mag : a_mag;
                    if (div_zero) begin
                        hi <= {1'b0, a};
                        lo <= '1;
                    end else begin
                        hi <= '0;
                        lo <= is_div ? a_mag : b_mag;
                    end
`ifdef MULDIV_SIGNED_EN
                    neg_q  <= a_neg ^ b_neg;
                    rneg_q <= a_neg;
                    dz_q   <= div_zero;
`endif
                end
                RUN: begin
                    count <= count + CNT_W'(1);
                    if (op_q[1]) begin
                        hi <= div_ge ? div_sub : div_shift;
                        lo <= {lo[XLEN-2:0], div_ge};
                    end else begin
                        hi <= {1'b0, mul_sum[XLEN:1]};
                        lo <= {mul_sum[0], lo[XLEN-1:1]};
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        prod = {hi[XLEN-1:0], lo};
        quo  = lo;
        remv = hi[XLEN-1:0];
`ifdef MULDIV_SIGNED_EN
        // Divide-by-zero results are architectural constants and bypass the fixup.
        if (!dz_q && neg_q)  prod = -prod;
        if (!dz_q && neg_q)  quo  = -quo;
        if (!dz_q && rneg_q) remv = -remv;
`endif
        case (op_q)
            OP_MUL:  res_sel = prod[XLEN-1:0];
            OP_MULH: res_sel = prod[2*XLEN-1:XLEN];
            OP_DIV:  res_sel = quo;
            default: res_sel = remv;
        endcase
    end

    always_comb begin
        stall    = 1'b0;
        done     = 1'b0;
        result   = '0;
        rd_out   = '0;
        regwrite = 1'b0;
        case (state)
            IDLE: stall = start;
            RUN:  stall = 1'b1;
            DONE: begin
                done     = 1'b1;
                result   = res_sel;
                rd_out   = rd_q;
                regwrite = (rd_q != 5'd0);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: latency, results, divide-by-zero, rd=0, reset mid-run.
// Signed expectations switch on MULDIV_SIGNED_EN.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic        sgn;
    logic [31:0] a, b;
    logic [4:0]  rd_in;
    logic        stall, done, regwrite;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int errors = 0;
    int checks = 0;

    int          ns;
    logic [31:0] r;
    logic [4:0]  rdo;
    logic        rw, da;

    muldiv_sequencer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .sgn      (sgn),
        .a        (a),
        .b        (b),
        .rd_in    (rd_in),
        .stall    (stall),
        .done     (done),
        .result   (result),
        .rd_out   (rd_out),
        .regwrite (regwrite)
    );

    always #5 clk = ~clk;

    // Issue one op, hold start until done, scramble operands after capture.
    // n_stall = -1 if done never arrives.
    task automatic do_op(input logic [1:0] op_i, input logic sgn_i, input logic [31:0] a_i,
                         input logic [31:0] b_i, input logic [4:0] rd_i,
                         output int n_stall, output logic [31:0] res_o, output logic [4:0] rd_o,
                         output logic rw_o, output logic done_after);
        logic got;
        @(negedge clk);
        start = 1'b1; op = op_i; sgn = sgn_i; a = a_i; b = b_i; rd_in = rd_i;
        #1;
        n_stall = 0;
        got = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            if (stall) n_stall++;
            @(negedge clk);
            #1;
            if (c == 0) begin
                a = $urandom; b = $urandom; op = 2'($urandom); rd_in = 5'($urandom);
            end
        end
        if (!got) n_stall = -1;
        res_o = result;
        rd_o  = rd_out;
        rw_o  = regwrite;
        start = 1'b0;
        @(negedge clk);
        #1;
        done_after = done | stall;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; op = 2'b00; sgn = 1'b0; a = '0; b = '0; rd_in = '0;
        #3;
        checks++; if (stall !== 1'b0)     begin errors++; $display("FAIL reset_stall: got %b want 0", stall); end
        checks++; if (done !== 1'b0)      begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (result !== 32'h0)   begin errors++; $display("FAIL reset_result: got %h want 0", result); end
        checks++; if (rd_out !== 5'd0)    begin errors++; $display("FAIL reset_rd_out: got %0d want 0", rd_out); end
        checks++; if (regwrite !== 1'b0)  begin errors++; $display("FAIL reset_regwrite: got %b want 0", regwrite); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_mul();
        do_op(2'b00, 1'b0, 32'd7, 32'd6, 5'd5, ns, r, rdo, rw, da);
        checks++; if (ns !== 33)          begin errors++; $display("FAIL mul_stall: got %0d want 33", ns); end
        checks++; if (r !== 32'd42)       begin errors++; $display("FAIL mul_result: got %h want 2a", r); end
        checks++; if (rdo !== 5'd5)       begin errors++; $display("FAIL mul_rd_out: got %0d want 5", rdo); end
        checks++; if (rw !== 1'b1)        begin errors++; $display("FAIL mul_regwrite: got %b want 1", rw); end
        checks++; if (da !== 1'b0)        begin errors++; $display("FAIL mul_one_cycle: got %b want 0", da); end
        do_op(2'b00, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1, ns, r, rdo, rw, da);
        checks++; if (r !== 32'h1)        begin errors++; $display("FAIL mul_lo_max: got %h want 1", r); end
        do_op(2'b01, 1'b0, 32'h80000000, 32'd2, 5'd1, ns, r, rdo, rw, da);
        checks++; if (r !== 32'h1)        begin errors++; $display("FAIL mulh_carry: got %h want 1", r); end
    endtask

    task automatic test_mulh();
        do_op(2'b01, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd9, ns, r, rdo, rw, da);
        checks++; if (r !== 32'hFFFFFFFE) begin errors++; $display("FAIL mulhu_max: got %h want fffffffe", r); end
        checks++; if (ns !== 33)          begin errors++; $display("FAIL mulh_stall: got %0d want 33", ns); end
        do_op(2'b01, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd9, ns, r, rdo, rw, da);
`ifdef MULDIV_SIGNED_EN
        checks++; if (r !== 32'h0)        begin errors++; $display("FAIL mulh_signed: got %h want 0", r); end
`else
        checks++; if (r !== 32'hFFFFFFFE) begin errors++; $display("FAIL mulh_sgn_ignored: got %h want fffffffe", r); end
`endif
    endtask

    task automatic test_div();
        do_op(2'b10, 1'b0, 32'd100, 32'd7, 5'd3, ns, r, rdo, rw, da);
        checks++; if (r !== 32'd14)       begin errors++; $display("FAIL div_result: got %h want e", r); end
        checks++; if (ns !== 33)          begin errors++; $display("FAIL div_stall: got %0d want 33", ns); end
        do_op(2'b11, 1'b0, 32'd100, 32'd7, 5'd3, ns, r, rdo, rw, da);
        checks++; if (r !== 32'd2)        begin errors++; $display("FAIL rem_result: got %h want 2", r); end
        checks++; if (ns !== 33)          begin errors++; $display("FAIL rem_stall: got %0d want 33", ns); end
        do_op(2'b10, 1'b0, 32'hFFFFFFFF, 32'h10, 5'd3, ns, r, rdo, rw, da);
        checks++; if (r !== 32'h0FFFFFFF) begin errors++; $display("FAIL div_big: got %h want 0fffffff", r); end
        do_op(2'b11, 1'b0, 32'hFFFFFFFF, 32'h10, 5'd3, ns, r, rdo, rw, da);
        checks++; if (r !== 32'hF)        begin errors++; $display("FAIL rem_big: got %h want f", r); end
    endtask

    task automatic test_div_zero();
        do_op(2'b10, 1'b0, 32'd123, 32'd0, 5'd7, ns, r, rdo, rw, da);
        checks++; if (ns !== 1)           begin errors++; $display("FAIL divz_stall: got %0d want 1", ns); end
        checks++; if (r !== 32'hFFFFFFFF) begin errors++; $display("FAIL divz_result: got %h want ffffffff", r); end
        checks++; if (da !== 1'b0)        begin errors++; $display("FAIL divz_one_cycle: got %b want 0", da); end
        do_op(2'b11, 1'b0, 32'd123, 32'd0, 5'd7, ns, r, rdo, rw, da);
        checks++; if (ns !== 1)           begin errors++; $display("FAIL remz_stall: got %0d want 1", ns); end
        checks++; if (r !== 32'd123)      begin errors++; $display("FAIL remz_result: got %h want 7b", r); end
        do_op(2'b11, 1'b1, 32'hFFFFFFF8, 32'd0, 5'd7, ns, r, rdo, rw, da);
        checks++; if (r !== 32'hFFFFFFF8) begin errors++; $display("FAIL remz_neg: got %h want fffffff8", r); end
        do_op(2'b10, 1'b1, 32'hFFFFFFF8, 32'd0, 5'd7, ns, r, rdo, rw, da);
        checks++; if (r !== 32'hFFFFFFFF) begin errors++; $display("FAIL divz_neg: got %h want ffffffff", r); end
    endtask

    task automatic test_signed();
`ifdef MULDIV_SIGNED_EN
        do_op(2'b10, 1'b1, 32'h80000000, 32'hFFFFFFFF, 5'd2, ns, r, rdo, rw, da);
        checks++; if (r !== 32'h80000000) begin errors++; $display("FAIL sdiv_ovf: got %h want 80000000", r); end
        checks++; if (ns !== 33)          begin errors++; $display("FAIL sdiv_ovf_stall: got %0d want 33", ns); end
        do_op(2'b11, 1'b1, 32'h80000000, 32'hFFFFFFFF, 5'd2, ns, r, rdo, rw, da);
        checks++; if (r !== 32'h0)        begin errors++; $display("FAIL srem_ovf: got %h want 0", r); end
        do_op(2'b10, 1'b1, 32'hFFFFFFF9, 32'd2, 5'd2, ns, r, rdo, rw, da);
        checks++; if (r !== 32'hFFFFFFFD) begin errors++; $display("FAIL sdiv_neg: got %h want fffffffd", r); end
        do_op(2'b11, 1'b1, 32'hFFFFFFF9, 32'd2, 5'd2, ns, r, rdo, rw, da);
        checks++; if (r !== 32'hFFFFFFFF) begin errors++; $display("FAIL srem_neg: got %h want ffffffff", r); end
`else
        do_op(2'b10, 1'b1, 32'h80000000, 32'hFFFFFFFF, 5'd2, ns, r, rdo, rw, da);
        checks++; if (r !== 32'h0)        begin errors++; $display("FAIL udiv_ovf: got %h want 0", r); end
        do_op(2'b11, 1'b1, 32'h80000000, 32'hFFFFFFFF, 5'd2, ns, r, rdo, rw, da);
        checks++; if (r !== 32'h80000000) begin errors++; $display("FAIL urem_ovf: got %h want 80000000", r); end
        do_op(2'b10, 1'b1, 32'hFFFFFFF9, 32'd2, 5'd2, ns, r, rdo, rw, da);
        checks++; if (r !== 32'h7FFFFFFC) begin errors++; $display("FAIL udiv_big: got %h want 7ffffffc", r); end
        do_op(2'b11, 1'b1, 32'hFFFFFFF9, 32'd2, 5'd2, ns, r, rdo, rw, da);
        checks++; if (r !== 32'h1)        begin errors++; $display("FAIL urem_big: got %h want 1", r); end
`endif
    endtask

    task automatic test_rd_zero();
        do_op(2'b00, 1'b0, 32'd11, 32'd13, 5'd0, ns, r, rdo, rw, da);
        checks++; if (ns !== 33)          begin errors++; $display("FAIL rd0_stall: got %0d want 33", ns); end
        checks++; if (r !== 32'd143)      begin errors++; $display("FAIL rd0_result: got %h want 8f", r); end
        checks++; if (rw !== 1'b0)        begin errors++; $display("FAIL rd0_regwrite: got %b want 0", rw); end
    endtask

    task automatic test_reset_mid_run();
        logic seen;
        @(negedge clk);
        start = 1'b1; op = 2'b00; sgn = 1'b0; a = 32'd3; b = 32'd5; rd_in = 5'd4;
        repeat (11) @(negedge clk);
        rst_n = 1'b0;
        start = 1'b0;
        #1;
        checks++; if (stall !== 1'b0)     begin errors++; $display("FAIL midrst_stall: got %b want 0", stall); end
        checks++; if (done !== 1'b0)      begin errors++; $display("FAIL midrst_done: got %b want 0", done); end
        checks++; if (result !== 32'h0)   begin errors++; $display("FAIL midrst_result: got %h want 0", result); end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            #1;
            if (done || stall) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0)      begin errors++; $display("FAIL midrst_no_done: got %b want 0", seen); end
        do_op(2'b00, 1'b0, 32'd3, 32'd3, 5'd8, ns, r, rdo, rw, da);
        checks++; if (r !== 32'd9)        begin errors++; $display("FAIL midrst_mul: got %h want 9", r); end
        checks++; if (ns !== 33)          begin errors++; $display("FAIL midrst_mul_stall: got %0d want 33", ns); end
        checks++; if (rdo !== 5'd8)       begin errors++; $display("FAIL midrst_rd_out: got %0d want 8", rdo); end
    endtask

    task automatic test_back_to_back();
        do_op(2'b11, 1'b0, 32'd1000, 32'd33, 5'd12, ns, r, rdo, rw, da);
        checks++; if (r !== 32'd10)       begin errors++; $display("FAIL b2b_rem: got %h want a", r); end
        do_op(2'b01, 1'b0, 32'h00010000, 32'h00030000, 5'd13, ns, r, rdo, rw, da);
        checks++; if (r !== 32'h3)        begin errors++; $display("FAIL b2b_mulh: got %h want 3", r); end
        checks++; if (rdo !== 5'd13)      begin errors++; $display("FAIL b2b_rd_out: got %0d want 13", rdo); end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_mulh();
        test_div();
        test_div_zero();
        test_signed();
        test_rd_zero();
        test_reset_mid_run();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
